wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter: ALU results win, load/mul/div results buffered in a FIFO
// Squashing keeps a younger ALU write from being overwritten by an older buffered result.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_rd,
  input  logic [31:0]                   alu_data,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [4:0]                    lsu_rd,
  input  logic [31:0]                   lsu_data,
  output logic                          rf_write_enable,
  output logic [4:0]                    rf_write_addr,
  output logic [31:0]                   rf_write_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [31:0]                   busy_mask
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [4:0]            rd_mem   [FIFO_DEPTH];
  logic [31:0]           data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld_mem;
  logic                  reset_q;
  logic                  alu_write;
  logic                  accept;
  logic                  push;
  logic                  pop;

  // reset_q holds lsu_ready low for the first cycle after reset is released
  assign lsu_ready = !reset && !reset_q && (fifo_count < DEPTH_C);
  assign alu_write = alu_valid && (alu_rd != 5'd0);
  assign accept    = lsu_valid && lsu_ready;
  assign push      = accept && (lsu_rd != 5'd0);
  assign pop       = !alu_write && (fifo_count != '0);

  always_ff @(posedge clk) begin
    reset_q <= reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= lsu_rd;
      data_mem[wr_ptr] <= lsu_data;
    end
  end

  // Later assignments win: a same-edge push is never squashed, freed slots read as invalid
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_mem <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (alu_write && (rd_mem[i] == alu_rd)) vld_mem[i] <= 1'b0;
      end
      if (pop)  vld_mem[rd_ptr] <= 1'b0;
      if (push) vld_mem[wr_ptr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_enable <= 1'b0;
      rf_write_addr   <= 5'd0;
      rf_write_data   <= 32'd0;
    end else if (alu_write) begin
      rf_write_enable <= 1'b1;
      rf_write_addr   <= alu_rd;
      rf_write_data   <= alu_data;
    end else if (pop) begin
      rf_write_enable <= vld_mem[rd_ptr];
      if (vld_mem[rd_ptr]) begin
        rf_write_addr <= rd_mem[rd_ptr];
        rf_write_data <= data_mem[rd_ptr];
      end
    end else begin
      rf_write_enable <= 1'b0;
    end
  end

  always_comb begin
    busy_mask = 32'd0;
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (vld_mem[i]) busy_mask[rd_mem[i]] = 1'b1;
      end
    end
  end

endmodule
